// File: rtl/enemy_spawn_pkg.sv
// Shared types and widths for the enemy spawn scheduler and its helpers.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package enemy_spawn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAW  = 2'd2,
    OFFER = 2'd3
  } state_e;

  localparam int LANE_W     = 3;
  localparam int TYPE_W     = 2;
  localparam int CNT_W      = 8;
  localparam int LEVEL_W    = 2;
  localparam int JITTER_MSB = 15;
  localparam int JITTER_LSB = 12;
  // Reject counter width; holds MAX_REJECT values up to 15.
  localparam int REJ_W      = 4;

  // Enemy type never exceeds the current difficulty level.
  function automatic logic [TYPE_W-1:0] clamp_type(input logic [TYPE_W-1:0]  raw,
                                                   input logic [LEVEL_W-1:0] level);
    return (raw > level) ? level : raw;
  endfunction

endpackage

// File: rtl/spawn_interval_calc.sv
// Loaded spawn interval: max(BASE - level*STEP, MIN) + jitter, 8-bit result.
// Latency: combinational. Backpressure: none.
// Ports: level_i difficulty 0..3, jitter_i random 0..15, interval_o tick count.
module spawn_interval_calc
  import enemy_spawn_pkg::*;
#(
  parameter int BASE_INTERVAL = 40,
  parameter int LEVEL_STEP    = 8,
  parameter int MIN_INTERVAL  = 12
) (
  input  logic [LEVEL_W-1:0]             level_i,
  input  logic [JITTER_MSB-JITTER_LSB:0] jitter_i,
  output logic [CNT_W-1:0]               interval_o
);

  // Signed 32-bit arithmetic so a large level*STEP goes negative and is
  // caught by the floor instead of wrapping to a huge unsigned interval.
  int nominal;

  always_comb begin
    nominal = BASE_INTERVAL - int'(level_i) * LEVEL_STEP;
    if (nominal < MIN_INTERVAL) begin
      nominal = MIN_INTERVAL;
    end
    // Parameters are chosen so nominal + 15 fits in the 8-bit counter.
    interval_o = CNT_W'(nominal + int'(jitter_i));
  end

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Turns the LFSR word into paced spawn requests (lane + type) for the enemy table.
// Latency: DRAW one cycle after the interval counter hits 0, OFFER after 1 + rejects.
// Backpressure: offer held stable (even if enable drops) until spawn_ready; ticks then are dropped.
// Ports: clk/rst (sync, active-high), enable, tick, level, rand_in in;
//        spawn_valid/lane/type out with spawn_ready in; spawn_count = accepted spawns mod 256.
module enemy_spawn_scheduler
  import enemy_spawn_pkg::*;
#(
  parameter int NUM_LANES     = 6,   // legal range 5..8
  parameter int BASE_INTERVAL = 40,
  parameter int LEVEL_STEP    = 8,
  parameter int MIN_INTERVAL  = 12,
  parameter int MAX_REJECT    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               tick,
  input  logic [LEVEL_W-1:0] level,
  input  logic [15:0]        rand_in,
  input  logic               spawn_ready,
  output logic               spawn_valid,
  output logic [LANE_W-1:0]  spawn_lane,
  output logic [TYPE_W-1:0]  spawn_type,
  output logic [CNT_W-1:0]   spawn_count
);

  // One extra bit so NUM_LANES = 8 is representable in compares.
  localparam logic [LANE_W:0]  NUM_LANES_W  = (LANE_W+1)'(NUM_LANES);
  localparam logic [REJ_W-1:0] MAX_REJECT_W = REJ_W'(MAX_REJECT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LANE_W-1:0]   last_lane_q, last_lane_d;
  logic [REJ_W-1:0]    rej_q, rej_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [CNT_W-1:0]    load_interval;
  logic [LANE_W-1:0]   cand;
  logic                cand_oob;
  logic                cand_reject;
  logic                rej_exhausted;
  logic [LANE_W-1:0]   fallback_lane;
  logic [TYPE_W-1:0]   draw_type;
  logic                unused_rand;

  spawn_interval_calc #(
    .BASE_INTERVAL (BASE_INTERVAL),
    .LEVEL_STEP    (LEVEL_STEP),
    .MIN_INTERVAL  (MIN_INTERVAL)
  ) u_interval (
    .level_i    (level),
    .jitter_i   (rand_in[JITTER_MSB:JITTER_LSB]),
    .interval_o (load_interval)
  );

  assign unused_rand = ^{rand_in[11:6], rand_in[3]};

  // Lane draw. Repeating the previous lane is only a rejection once a spawn
  // has actually been accepted; after reset last_lane carries no history.
  always_comb begin
    cand          = rand_in[LANE_W-1:0];
    cand_oob      = ({1'b0, cand} >= NUM_LANES_W);
    cand_reject   = cand_oob || ((cand == last_lane_q) && (count_q != '0));
    rej_exhausted = (rej_q >= MAX_REJECT_W);
    draw_type     = clamp_type(rand_in[5:4], level);
    // Fallback folds out-of-range draws back into range, and steps an
    // in-range repeat to the next lane so the mapping always terminates.
    if (cand_oob) begin
      fallback_lane = LANE_W'({1'b0, cand} - NUM_LANES_W);
    end else if (({1'b0, cand} + (LANE_W+1)'(1)) == NUM_LANES_W) begin
      fallback_lane = '0;
    end else begin
      fallback_lane = cand + LANE_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT;
      end
      WAIT: begin
        if (!enable)           state_d = IDLE;
        else if (cnt_q == '0)  state_d = DRAW;
      end
      DRAW: begin
        if (!enable)                          state_d = IDLE;
        else if (!cand_reject || rej_exhausted) state_d = OFFER;
      end
      OFFER: begin
        // enable is only consulted once the offer has been taken.
        if (spawn_ready) state_d = enable ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: interval counter, reject count, latched request.
  always_comb begin
    cnt_d       = cnt_q;
    last_lane_d = last_lane_q;
    rej_d       = rej_q;
    lane_d      = lane_q;
    type_d      = type_q;
    count_d     = count_q;
    unique case (state_q)
      IDLE: begin
        if (enable) cnt_d = load_interval;
      end
      WAIT: begin
        if (enable && tick && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
      end
      DRAW: begin
        if (!enable) begin
          rej_d = '0;
        end else if (!cand_reject) begin
          lane_d = cand;
          type_d = draw_type;
          rej_d  = '0;
        end else if (rej_exhausted) begin
          lane_d = fallback_lane;
          type_d = draw_type;
          rej_d  = '0;
        end else begin
          rej_d = rej_q + REJ_W'(1);
        end
      end
      OFFER: begin
        if (spawn_ready) begin
          count_d     = count_q + CNT_W'(1);
          last_lane_d = lane_q;
          if (enable) cnt_d = load_interval;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      last_lane_q <= '0;
      rej_q       <= '0;
      lane_q      <= '0;
      type_q      <= '0;
      count_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      last_lane_q <= last_lane_d;
      rej_q       <= rej_d;
      lane_q      <= lane_d;
      type_q      <= type_d;
      count_q     <= count_d;
    end
  end

  // Outputs.
  always_comb begin
    spawn_valid = (state_q == OFFER);
    spawn_lane  = lane_q;
    spawn_type  = type_q;
    spawn_count = count_q;
  end

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed bench for enemy_spawn_scheduler with hand-computed expectations.
// Latency: n/a. Backpressure: exercised by holding spawn_ready low.
// Also checks the interval helper standalone with BASE_INTERVAL=20.
module tb_enemy_spawn_scheduler;
  import enemy_spawn_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        tick;
  logic [1:0]  level;
  logic [15:0] rand_in;
  logic        spawn_ready;
  logic        spawn_valid;
  logic [2:0]  spawn_lane;
  logic [1:0]  spawn_type;
  logic [7:0]  spawn_count;

  logic [1:0]  c20_level;
  logic [3:0]  c20_jitter;
  logic [7:0]  c20_interval;

  int n_tests = 0;
  int n_fail  = 0;
  int hs      = 0;
  bit seen255 = 1'b0;

  always #5 clk = ~clk;

  enemy_spawn_scheduler #(
    .NUM_LANES(6), .BASE_INTERVAL(40), .LEVEL_STEP(8), .MIN_INTERVAL(12), .MAX_REJECT(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .tick        (tick),
    .level       (level),
    .rand_in     (rand_in),
    .spawn_ready (spawn_ready),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .spawn_type  (spawn_type),
    .spawn_count (spawn_count)
  );

  spawn_interval_calc #(
    .BASE_INTERVAL(20), .LEVEL_STEP(8), .MIN_INTERVAL(12)
  ) u_calc20 (
    .level_i    (c20_level),
    .jitter_i   (c20_jitter),
    .interval_o (c20_interval)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; tick = 1'b0; level = 2'd0;
    rand_in = 16'h0000; spawn_ready = 1'b0;
    c20_level = 2'd0; c20_jitter = 4'd0;

    // Interval helper with BASE=20: floor at 12 from level 1 upward.
    #1;
    c20_level = 2'd3; c20_jitter = 4'd0;  #1; check_eq("calc20_l3_j0", c20_interval, 12);
    c20_level = 2'd0; c20_jitter = 4'd15; #1; check_eq("calc20_l0_j15", c20_interval, 35);
    c20_level = 2'd2; c20_jitter = 4'd5;  #1; check_eq("calc20_l2_j5", c20_interval, 17);

    // Reset state.
    step(); step();
    check_eq("rst_valid", spawn_valid, 0);
    check_eq("rst_lane",  spawn_lane, 0);
    check_eq("rst_type",  spawn_type, 0);
    check_eq("rst_count", spawn_count, 0);
    check_eq("rst_state", dut.state_q, IDLE);

    // Level 0, jitter 3 -> 43 ticks.
    rst = 1'b0; level = 2'd0; rand_in = 16'h3002; enable = 1'b1;
    step();
    check_eq("load43_state", dut.state_q, WAIT);
    check_eq("load43_cnt",   dut.cnt_q, 43);
    tick = 1'b1;
    repeat (42) step();
    check_eq("cnt_at_1", dut.cnt_q, 1);
    step();
    check_eq("cnt_at_0", dut.cnt_q, 0);
    check_eq("wait_at_0", dut.state_q, WAIT);
    tick = 1'b0;
    step();
    check_eq("draw_state", dut.state_q, DRAW);
    check_eq("draw_valid", spawn_valid, 0);
    step();
    check_eq("offer1_valid", spawn_valid, 1);
    check_eq("offer1_lane",  spawn_lane, 2);
    check_eq("offer1_type",  spawn_type, 0);
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
    check_eq("acc1_count", spawn_count, 1);
    check_eq("acc1_valid", spawn_valid, 0);
    check_eq("acc1_reload", dut.cnt_q, 43);

    // Enable drop in WAIT.
    enable = 1'b0;
    step();
    check_eq("wait_drop_state", dut.state_q, IDLE);
    check_eq("wait_drop_valid", spawn_valid, 0);

    // Level 3 clamp: 40-24=16, jitter 0 -> 16. Then last-lane repeat rejected.
    level = 2'd3; rand_in = 16'h0000; enable = 1'b1;
    step();
    check_eq("l3_cnt", dut.cnt_q, 16);
    tick = 1'b1;
    repeat (16) step();
    step();
    check_eq("l3_draw", dut.state_q, DRAW);
    rand_in = 16'h0002;
    step();
    check_eq("repeat_rejected", dut.state_q, DRAW);
    rand_in = 16'h0014;
    step();
    check_eq("repeat_next_valid", spawn_valid, 1);
    check_eq("repeat_next_lane",  spawn_lane, 4);
    check_eq("repeat_next_type",  spawn_type, 1);

    // Hold offer with ready low; enable dropped mid-offer must not withdraw it.
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_in = 16'($urandom);
      step();
      check_eq("hold_valid", spawn_valid, 1);
      check_eq("hold_lane",  spawn_lane, 4);
      check_eq("hold_type",  spawn_type, 1);
    end
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
    check_eq("hold_acc_count", spawn_count, 2);
    check_eq("hold_acc_valid", spawn_valid, 0);
    check_eq("hold_acc_state", dut.state_q, IDLE);

    // Rejection chain 7,6,7,7 -> fallback lane 1 at level 2 (interval 24).
    level = 2'd2; rand_in = 16'h0000; enable = 1'b1;
    step();
    check_eq("l2_cnt", dut.cnt_q, 24);
    repeat (24) step();
    step();
    rand_in = 16'h0007; step();
    rand_in = 16'h0006; step();
    rand_in = 16'h0007; step();
    check_eq("rej3_state", dut.state_q, DRAW);
    check_eq("rej3_valid", spawn_valid, 0);
    rand_in = 16'h0037; step();
    check_eq("fallback_valid", spawn_valid, 1);
    check_eq("fallback_lane",  spawn_lane, 1);
    check_eq("fallback_type",  spawn_type, 2);
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
    check_eq("acc3_count", spawn_count, 3);
    check_eq("acc3_state", dut.state_q, WAIT);
    check_eq("acc3_reload", dut.cnt_q, 24);

    // Reset while offering.
    repeat (24) step();
    step();
    rand_in = 16'h0003;
    step();
    check_eq("pre_rst_valid", spawn_valid, 1);
    check_eq("pre_rst_lane",  spawn_lane, 3);
    rst = 1'b1;
    step();
    check_eq("mid_rst_valid", spawn_valid, 0);
    check_eq("mid_rst_count", spawn_count, 0);
    check_eq("mid_rst_state", dut.state_q, IDLE);
    rst = 1'b0;

    // 256 accepts: count passes 255 and wraps to 0.
    level = 2'd3; enable = 1'b1; tick = 1'b1; spawn_ready = 1'b1;
    for (int cyc = 0; cyc < 20000 && hs < 256; cyc++) begin
      rand_in = (cyc % 2 == 1) ? 16'h0003 : 16'h0000;
      if (spawn_valid) hs++;
      step();
      if (hs == 255 && !seen255) begin
        seen255 = 1'b1;
        check_eq("count_255", spawn_count, 255);
      end
    end
    check_eq("wrap_accepts", hs, 256);
    check_eq("count_wrap", spawn_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_spawn_scheduler.md
Name: enemy_spawn_scheduler

Overview:
- Consumes the free-running 16-bit pseudo-random word from the LFSR and turns it into paced enemy spawn requests: when to spawn, which lane, and which enemy type.
- Sits between the LFSR and the enemy object table.
- Issues one spawn per randomised interval, measured in game frame ticks.
- Hands each spawn over with a valid/ready handshake.

Parameters:
- NUM_LANES, 6, number of legal lanes; must be in the range 5..8.
- BASE_INTERVAL, 40, nominal ticks between spawns at level 0.
- LEVEL_STEP, 8, ticks removed from the nominal interval per level.
- MIN_INTERVAL, 12, floor for the nominal interval.
- MAX_REJECT, 3, lane draws rejected before the fallback mapping is forced.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  spawning permitted (game running)
- tick  in  1  one-cycle frame-tick pulse
- level  in  2  difficulty level 0..3
- rand_in  in  16  LFSR output; changes every clk
- spawn_ready  in  1  enemy table accepts a request
- spawn_valid  out  1  request pending
- spawn_lane  out  3  lane 0..NUM_LANES-1
- spawn_type  out  2  enemy type 0..level
- spawn_count  out  8  accepted spawns since reset; wraps at 255->0

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; all state updates on posedge clk.
- Reset values: state=IDLE, spawn_valid=0, spawn_lane=0, spawn_type=0, spawn_count=0, interval counter=0, last_lane=0, reject count=0.
- Reset mid-operation: rst asserted during any state, including OFFER, drops spawn_valid on the next edge. The pending request is discarded and not counted.
- Nominal interval: max(BASE_INTERVAL - level*LEVEL_STEP, MIN_INTERVAL).
  - Computed signed or with a guard so the subtraction never underflows.
  - Loaded interval = nominal + rand_in[15:12] (jitter 0..15). The counter is 8 bits.
- IDLE:
  - enable=1: load the interval from the current rand_in and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - tick=1 and counter!=0: decrement the counter.
  - counter==0: go to DRAW on the next clk (no tick needed).
  - enable=0: go to IDLE; the counter value is abandoned.
- DRAW (one cycle per attempt, so rand_in differs on each attempt):
  - Candidate lane c = rand_in[2:0].
  - c is rejected if c>=NUM_LANES, or if c==last_lane and spawn_count!=0.
  - Accept: latch spawn_lane=c and spawn_type=min(rand_in[5:4], level); clear the reject count; go to OFFER.
  - Reject while reject count < MAX_REJECT: increment the reject count and stay in DRAW.
  - Reject with reject count == MAX_REJECT: forced fallback.
    - Lane = c - NUM_LANES if c>=NUM_LANES, else (c+1) mod NUM_LANES.
    - Latch and go to OFFER.
  - enable=0: go to IDLE.
- OFFER:
  - spawn_valid=1. spawn_lane and spawn_type stay stable until accepted.
  - Deasserting enable does NOT withdraw the offer.
  - On spawn_valid & spawn_ready: spawn_count += 1; last_lane = spawn_lane; spawn_valid=0 next cycle.
    - enable=1: reload the interval from the current rand_in and go to WAIT.
    - enable=0: go to IDLE.
  - Ticks arriving during OFFER or DRAW are ignored; they are not queued.
- Latency: from the counter reaching 0, spawn_valid rises after 1 + (number of rejects) cycles. The handshake completes in the cycle where valid and ready are both 1.
- A tick coinciding with WAIT entry is ignored in that cycle. Simultaneous tick and counter==1 yields counter=0, and DRAW follows one cycle later.

Decomposition:
- Package enemy_spawn_pkg:
  - state enum {IDLE, WAIT, DRAW, OFFER}
  - LANE_W=3, TYPE_W=2, CNT_W=8, JITTER_MSB=15, JITTER_LSB=12
- Sub-module spawn_interval_calc: combinational; inputs level and rand_in[15:12]; output the 8-bit loaded interval with clamping. It is also reused by the boss-wave timer.
- FSM, lane draw and counters stay in the top module.

Test Plan:
- The bench drives rand_in directly, no LFSR. Parameters: NUM_LANES=6, BASE=40, STEP=8, MIN=12, MAX_REJECT=3.
- Interval: level=0, rand_in=16'h3002 on enable -> counter 43; after 43 ticks DRAW; lane=2, type=0; spawn_valid rises at the expected cycle.
- Level clamp: level=3, jitter=0 -> nominal 16 (not 40-24=16 underflowed) -> interval 16. Check level=3 with BASE=20 -> clamped to 12.
- Rejection: in DRAW, rand_in[2:0] sequence 7,6,7,7 -> fallback lane 1 after 3 rejects (4 DRAW cycles). Also last_lane=2, candidate 2 then 4 -> lane 4.
- Handshake hold: spawn_ready low for 10 cycles, rand_in changing -> lane/type stable and valid high. ready=1 -> spawn_count increments by exactly 1.
- Enable drop: enable=0 in WAIT -> IDLE next cycle, no spawn. enable=0 in OFFER -> offer persists until ready, then IDLE.
- Reset in OFFER: rst=1 -> spawn_valid=0 and spawn_count=0 next edge. Also spawn_count wraps 255->0 after 256 accepts.
